// File: rtl/decoder_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared types and helpers for the decoder_seq block.
//               mode_e  - command opcode carried on in_mode
//               state_e - controller state
//               onehot  - index -> one-hot vector (sized for the widest build)
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

  // Largest select width the onehot helper covers; callers truncate the result.
  localparam int SEL_MAX    = 8;
  localparam int ONEHOT_MAX = 2 ** SEL_MAX;

  typedef enum logic [1:0] {
    MODE_LATCH = 2'd0,
    MODE_PULSE = 2'd1,
    MODE_SCAN  = 2'd2,
    MODE_CLEAR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    PULSE = 2'd2,
    SCAN  = 2'd3
  } state_e;

  function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [SEL_MAX-1:0] idx);
    logic [ONEHOT_MAX-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : decoder_seq_if
// Description : Command / output bundle of decoder_seq.
//               master : command source (in_valid, in_sel, in_mode, in_hold)
//               slave  : decoder (in_ready, out_onehot, active, err)
// Revision    : 1.0 - initial release
// ============================================================================
interface decoder_seq_if #(
  parameter int SEL_W  = 2,
  parameter int HOLD_W = 8
);
  localparam int OUT_W = 2 ** SEL_W;

  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  in_sel;
  logic [1:0]        in_mode;
  logic [HOLD_W-1:0] in_hold;
  logic [OUT_W-1:0]  out_onehot;
  logic              active;
  logic              err;

  modport master (
    output in_valid, in_sel, in_mode, in_hold,
    input  in_ready, out_onehot, active, err
  );

  modport slave (
    input  in_valid, in_sel, in_mode, in_hold,
    output in_ready, out_onehot, active, err
  );

endinterface
`default_nettype wire

// File: rtl/decoder_seq_hold_cnt.sv
`default_nettype none
// ============================================================================
// Module      : dec_hold_cnt
// Description : Dwell counter shared by PULSE and SCAN.
//               load    : capture hold_in, restart count at 0
//               clr     : restart count at 0 (hold value kept)
//               inc     : count up by one
//               tc      : count has reached the captured hold value
// Revision    : 1.0 - initial release
// ============================================================================
module dec_hold_cnt #(
  parameter int HOLD_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              load,
  input  wire logic              clr,
  input  wire logic              inc,
  input  wire logic [HOLD_W-1:0] hold_in,
  output logic                   tc
);

  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (load) begin
      cnt_d  = '0;
      hold_d = hold_in;
    end else if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      // The controller clears on tc, so the count never passes hold_q.
      cnt_d = cnt_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      hold_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

  assign tc = (cnt_q == hold_q);

endmodule
`default_nettype wire

// File: rtl/decoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : decoder_seq
// Description : Registered binary-to-one-hot decoder with LATCH, PULSE, SCAN
//               and CLEAR commands on a valid/ready port.
//               clk, rst : clock, asynchronous active-high reset
//               bus      : decoder_seq_if.slave (command in, one-hot out)
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W  = 2,
  parameter int HOLD_W = 8
) (
  input wire logic     clk,
  input wire logic     rst,
  decoder_seq_if.slave bus
);

  localparam int OUT_W = 2 ** SEL_W;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] index_q, index_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             err_q, err_d;

  logic  ready;
  logic  accept;
  mode_e cmd_mode;
  logic  cnt_load, cnt_clr, cnt_inc, cnt_tc;

  function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] i);
    return OUT_W'(onehot(SEL_MAX'(i)));
  endfunction

  dec_hold_cnt #(.HOLD_W(HOLD_W)) u_hold_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .hold_in (bus.in_hold),
    .tc      (cnt_tc)
  );

  always_comb begin
    ready    = (state_q != PULSE);
    accept   = bus.in_valid && ready;
    cmd_mode = mode_e'(bus.in_mode);
    state_d  = state_q;
    index_d  = index_q;
    out_d    = out_q;
    err_d    = bus.in_valid && !ready;
    cnt_load = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;

    if (accept) begin
      // A new command always preempts; any pending scan advance is dropped.
      case (cmd_mode)
        MODE_LATCH: begin
          state_d  = LATCH;
          index_d  = bus.in_sel;
          out_d    = dec(bus.in_sel);
          cnt_load = 1'b1;
        end
        MODE_PULSE: begin
          state_d  = PULSE;
          index_d  = bus.in_sel;
          out_d    = dec(bus.in_sel);
          cnt_load = 1'b1;
        end
        MODE_SCAN: begin
          state_d  = SCAN;
          index_d  = bus.in_sel;
          out_d    = dec(bus.in_sel);
          cnt_load = 1'b1;
        end
        default: begin
          state_d = IDLE;
          out_d   = '0;
          cnt_clr = 1'b1;
        end
      endcase
    end else begin
      case (state_q)
        PULSE: begin
          if (cnt_tc) begin
            state_d = IDLE;
            out_d   = '0;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        SCAN: begin
          if (cnt_tc) begin
            // SEL_W-bit add wraps OUT_W-1 back to 0.
            index_d = index_q + SEL_W'(1);
            out_d   = dec(index_d);
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_onehot = out_q;
  assign bus.active     = (state_q != IDLE);
  assign bus.err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_seq
// Description : Self-checking bench for decoder_seq (SEL_W=2 and SEL_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_seq;

  logic clk;
  logic rst;

  decoder_seq_if #(.SEL_W(2), .HOLD_W(8)) bus0 ();
  decoder_seq_if #(.SEL_W(4), .HOLD_W(8)) bus1 ();

  decoder_seq #(.SEL_W(2), .HOLD_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  decoder_seq #(.SEL_W(4), .HOLD_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model for bus0: remembers what the last accepted command was and
  // how many edges have passed since, and derives the output from that.
  // --------------------------------------------------------------------------
  int         m_st;      // 0 idle, 1 latch, 2 pulse, 3 scan
  int         m_idx;
  int         m_hold;
  int         m_age;
  logic       exp_err;
  logic       drop_prev;
  logic       m_rdy;
  logic [3:0] one4 = 4'b0001;

  function automatic logic [3:0] model_out();
    case (m_st)
      1, 2:    return one4 << m_idx;
      3:       return one4 << ((m_idx + m_age / (m_hold + 1)) % 4);
      default: return 4'b0000;
    endcase
  endfunction

  initial begin
    m_st = 0; m_idx = 0; m_hold = 0; m_age = 0;
    exp_err = 1'b0; drop_prev = 1'b0; m_rdy = 1'b1;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_st = 0; m_idx = 0; m_hold = 0; m_age = 0;
        exp_err = 1'b0; drop_prev = 1'b0;
      end else begin
        m_rdy     = (m_st != 2);
        exp_err   = bus0.in_valid && !m_rdy;
        drop_prev = bus0.in_valid && !bus0.in_ready;
        if (bus0.in_valid && m_rdy) begin
          m_age = 0;
          case (bus0.in_mode)
            2'd0: begin m_st = 1; m_idx = int'(bus0.in_sel); end
            2'd1: begin m_st = 2; m_idx = int'(bus0.in_sel); m_hold = int'(bus0.in_hold); end
            2'd2: begin m_st = 3; m_idx = int'(bus0.in_sel); m_hold = int'(bus0.in_hold); end
            default: m_st = 0;
          endcase
        end else begin
          m_age++;
          if (m_st == 2 && m_age > m_hold) m_st = 0;
        end
      end
    end
  end

  // Per-cycle comparison of bus0 against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_on) begin
        chk("cyc_out",    32'(bus0.out_onehot), 32'(model_out()));
        chk("cyc_active", 32'(bus0.active),     32'(m_st != 0));
        chk("cyc_ready",  32'(bus0.in_ready),   32'(m_st != 2));
        chk("cyc_err",    32'(bus0.err),        32'(exp_err));
        chk("onehot_inv", 32'($countones(bus0.out_onehot) > 1), 32'(0));
        chk("err_cause",  32'(bus0.err && !drop_prev), 32'(0));
      end
    end
  end

  task automatic cmd0(input logic [1:0] mode, input logic [1:0] sel, input logic [7:0] hold);
    @(negedge clk);
    bus0.in_valid = 1'b1;
    bus0.in_mode  = mode;
    bus0.in_sel   = sel;
    bus0.in_hold  = hold;
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
  endtask

  task automatic cmd1(input logic [1:0] mode, input logic [3:0] sel, input logic [7:0] hold);
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.in_mode  = mode;
    bus1.in_sel   = sel;
    bus1.in_hold  = hold;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] scan_seq [6] = '{4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010, 4'b0010};

  initial begin
    rst = 1'b1;
    bus0.in_valid = 1'b0; bus0.in_mode = 2'd0; bus0.in_sel = '0; bus0.in_hold = '0;
    bus1.in_valid = 1'b0; bus1.in_mode = 2'd0; bus1.in_sel = '0; bus1.in_hold = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_out",    32'(bus0.out_onehot), 32'h0);
    chk("rst_active", 32'(bus0.active),     32'h0);
    chk("rst_err",    32'(bus0.err),        32'h0);
    chk("rst_ready",  32'(bus0.in_ready),   32'h1);
    chk("rst_out1",   32'(bus1.out_onehot), 32'h0);
    chk_on = 1'b1;

    // LATCH sel=2 held 20 cycles, then CLEAR
    cmd0(2'd0, 2'd2, 8'd0);
    chk("latch_out", 32'(bus0.out_onehot), 32'h4);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("latch_hold", 32'(bus0.out_onehot), 32'h4);
    end
    cmd0(2'd3, 2'd1, 8'd5);
    chk("clear_out",    32'(bus0.out_onehot), 32'h0);
    chk("clear_active", 32'(bus0.active),     32'h0);

    // PULSE sel=1 H=3 with a dropped command in the middle
    cmd0(2'd1, 2'd1, 8'd3);
    chk("pulse_out0",   32'(bus0.out_onehot), 32'h2);
    chk("pulse_ready0", 32'(bus0.in_ready),   32'h0);
    bus0.in_valid = 1'b1; bus0.in_mode = 2'd0; bus0.in_sel = 2'd3;
    step(1);
    bus0.in_valid = 1'b0;
    chk("pulse_err",    32'(bus0.err),        32'h1);
    chk("pulse_out1",   32'(bus0.out_onehot), 32'h2);
    step(1);
    chk("pulse_err_clr", 32'(bus0.err),       32'h0);
    chk("pulse_out2",   32'(bus0.out_onehot), 32'h2);
    step(1);
    chk("pulse_out3",   32'(bus0.out_onehot), 32'h2);
    chk("pulse_ready3", 32'(bus0.in_ready),   32'h0);
    step(1);
    chk("pulse_end",    32'(bus0.out_onehot), 32'h0);
    chk("pulse_ready4", 32'(bus0.in_ready),   32'h1);
    chk("pulse_active4", 32'(bus0.active),    32'h0);

    // SCAN sel=3 H=1 with wrap, then LATCH sel=0 on an advance edge
    cmd0(2'd2, 2'd3, 8'd1);
    chk("scan_0", 32'(bus0.out_onehot), 32'(scan_seq[0]));
    for (int i = 1; i < 6; i++) begin
      step(1);
      chk("scan_seq", 32'(bus0.out_onehot), 32'(scan_seq[i]));
    end
    cmd0(2'd0, 2'd0, 8'd0);
    chk("preempt_out", 32'(bus0.out_onehot), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("preempt_hold", 32'(bus0.out_onehot), 32'h1);
    end

    // SEL_W=4: PULSE sel=15 H=0
    cmd1(2'd1, 4'd15, 8'd0);
    chk("w4_out0",   32'(bus1.out_onehot), 32'h8000);
    chk("w4_ready0", 32'(bus1.in_ready),   32'h0);
    step(1);
    chk("w4_out1",   32'(bus1.out_onehot), 32'h0);
    chk("w4_ready1", 32'(bus1.in_ready),   32'h1);
    chk("w4_active1", 32'(bus1.active),    32'h0);

    // Asynchronous reset between edges mid-SCAN
    cmd0(2'd2, 2'd1, 8'd2);
    chk("scan2_out", 32'(bus0.out_onehot), 32'h2);
    step(2);
    #2 rst = 1'b1;
    #1;
    chk("arst_out",    32'(bus0.out_onehot), 32'h0);
    chk("arst_active", 32'(bus0.active),     32'h0);
    #2 rst = 1'b0;
    cmd0(2'd0, 2'd0, 8'd0);
    chk("post_rst_latch", 32'(bus0.out_onehot), 32'h1);

    // Random command stream
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      bus0.in_valid = ($urandom_range(0, 99) < 45);
      bus0.in_mode  = 2'($urandom_range(0, 3));
      bus0.in_sel   = 2'($urandom_range(0, 3));
      bus0.in_hold  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 20))
                                                   : 8'($urandom_range(0, 3));
    end
    @(negedge clk);
    bus0.in_valid = 1'b0;
    step(30);
    chk_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
